decode_stage: RTL and testbench

Registered, parametrised RV32I/RV64I instruction decode stage with a valid/ready handshake on both sides. It sits between the fetch stage and the execute stage. It turns a fetched instruction word plus its PC into registered register indices, a sign-extended immediate, operand selects and control flags. It adds illegal-instruction detection, optional M-extension and RV64 word-op decode, SYSTEM (ecall/ebreak) decode, and a pipeline flush.

---
 rtl/decode_stage.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: one-deep registered RV32I/RV64I decoder between fetch and execute.
// Holds one decoded instruction behind a valid/ready handshake on each side.
module decode_stage #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_ir_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic            funct7_o,
  output logic [XLEN-1:0] imm_o,
  output logic [1:0]      op_sel_o,
  output logic            reg_we_o,
  output logic            load_o,
  output logic            store_o,
  output logic            lui_o,
  output logic            auipc_o,
  output logic            branch_o,
  output logic            jal_o,
  output logic            jalr_o,
  output logic            muldiv_o,
  output logic            word_o,
  output logic            ecall_o,
  output logic            ebreak_o,
  output logic            illegal_o
);

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  typedef struct packed {
    logic reg_we;
    logic load;
    logic store;
    logic lui;
    logic auipc;
    logic branch;
    logic jal;
    logic jalr;
    logic muldiv;
    logic word;
    logic ecall;
    logic ebreak;
  } ctrl_t;

  // Sign-extend a 32-bit pre-formed immediate to the datapath width.
  function automatic logic signed [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Shift-immediate encoding check on ir[31:25]; chk25 rejects a 6-bit shamt.
  function automatic logic shift_ok(input logic [6:0] hi, input logic [2:0] f3,
                                    input logic chk25);
    logic top_ok;
    top_ok = (hi[6:1] == 6'b000000) || (f3 == 3'b101 && hi[6:1] == 6'b010000);
    return top_ok && !(chk25 && hi[0]);
  endfunction

  logic [31:0]             ir;
  logic [4:0]              opc;
  logic [2:0]              f3;
  logic [6:0]              f7;
  logic signed [XLEN-1:0]  imm_i, imm_s, imm_b, imm_j, imm_u;
  logic                    known, bad, illegal_d;
  ctrl_t                   raw, ctrl_d;
  logic [1:0]              os_raw, os_d;
  logic signed [XLEN-1:0]  imm_raw, imm_d;
  logic                    accept;

  assign ir    = in_ir_i;
  assign opc   = ir[6:2];
  assign f3    = ir[14:12];
  assign f7    = ir[31:25];
  assign imm_i = sext32({{20{ir[31]}}, ir[31:20]});
  assign imm_s = sext32({{20{ir[31]}}, ir[31:25], ir[11:7]});
  assign imm_b = sext32({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
  assign imm_j = sext32({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
  assign imm_u = sext32({ir[31:12], 12'b0});

  assign in_ready_o = !flush_i && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // Decode the incoming word; legality masks every control and immediate output.
  always_comb begin
    raw     = '0;
    os_raw  = 2'b00;
    imm_raw = '0;
    known   = 1'b0;
    bad     = 1'b0;
    case (opc)
      OPC_OP_IMM: begin
        known      = 1'b1;
        raw.reg_we = 1'b1;
        os_raw     = 2'b10;
        imm_raw    = imm_i;
        if (f3 == 3'b001 || f3 == 3'b101) bad = !shift_ok(f7, f3, XLEN == 32);
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          known      = 1'b1;
          raw.reg_we = 1'b1;
          raw.word   = 1'b1;
          os_raw     = 2'b10;
          imm_raw    = imm_i;
          if (f3 == 3'b001 || f3 == 3'b101) bad = !shift_ok(f7, f3, 1'b1);
        end
      end
      OPC_OP, OPC_OP_32: begin
        if (opc == OPC_OP || XLEN == 64) begin
          known      = 1'b1;
          raw.reg_we = 1'b1;
          raw.word   = (opc == OPC_OP_32);
          case (f7)
            7'b0000000: bad = 1'b0;
            7'b0100000: bad = !(f3 == 3'b000 || f3 == 3'b101);
            7'b0000001: begin
              raw.muldiv = 1'b1;
              bad = !EN_M || (opc == OPC_OP_32 && (f3 == 3'b001 || f3 == 3'b010 ||
                                                   f3 == 3'b011));
            end
            default:    bad = 1'b1;
          endcase
        end
      end
      OPC_LUI: begin
        known      = 1'b1;
        raw.reg_we = 1'b1;
        raw.lui    = 1'b1;
        os_raw     = 2'b10;
        imm_raw    = imm_u;
      end
      OPC_AUIPC: begin
        known      = 1'b1;
        raw.reg_we = 1'b1;
        raw.auipc  = 1'b1;
        os_raw     = 2'b11;
        imm_raw    = imm_u;
      end
      OPC_JAL: begin
        known      = 1'b1;
        raw.reg_we = 1'b1;
        raw.jal    = 1'b1;
        os_raw     = 2'b11;
        imm_raw    = imm_j;
      end
      OPC_JALR: begin
        known      = 1'b1;
        raw.reg_we = 1'b1;
        raw.jalr   = 1'b1;
        os_raw     = 2'b10;
        imm_raw    = imm_i;
        bad        = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        known      = 1'b1;
        raw.branch = 1'b1;
        imm_raw    = imm_b;
        bad        = (f3 == 3'b010 || f3 == 3'b011);
      end
      OPC_LOAD: begin
        known      = 1'b1;
        raw.reg_we = 1'b1;
        raw.load   = 1'b1;
        os_raw     = 2'b10;
        imm_raw    = imm_i;
        bad        = (f3 == 3'b111) || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OPC_STORE: begin
        known      = 1'b1;
        raw.store  = 1'b1;
        os_raw     = 2'b10;
        imm_raw    = imm_s;
        bad        = f3[2] || (XLEN == 32 && f3 == 3'b011);
      end
      OPC_MISC_MEM: known = 1'b1;
      OPC_SYSTEM: begin
        known      = 1'b1;
        raw.ecall  = (ir == 32'h0000_0073);
        raw.ebreak = (ir == 32'h0010_0073);
        bad        = !(raw.ecall || raw.ebreak);
      end
      default: known = 1'b0;
    endcase

    illegal_d = (ir[1:0] != 2'b11) || !known || bad;
    if (illegal_d) begin
      ctrl_d = '0;
      os_d   = 2'b00;
      imm_d  = '0;
    end else begin
      ctrl_d        = raw;
      ctrl_d.reg_we = raw.reg_we && (ir[11:7] != 5'd0);
      os_d          = os_raw;
      imm_d         = imm_raw;
    end
  end

  logic                   vld_p0;
  logic [XLEN-1:0]        pc_p0;
  logic [4:0]             rs1_p0, rs2_p0, rd_p0;
  logic [2:0]             f3_p0;
  logic                   f7_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [1:0]             os_p0;
  ctrl_t                  ctrl_p0;
  logic                   ill_p0;

  // ---- stage p0: output register, loaded on accept, cleared on consume/flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0  <= 1'b0;
      pc_p0   <= '0;
      rs1_p0  <= '0;
      rs2_p0  <= '0;
      rd_p0   <= '0;
      f3_p0   <= '0;
      f7_p0   <= 1'b0;
      imm_p0  <= '0;
      os_p0   <= '0;
      ctrl_p0 <= '0;
      ill_p0  <= 1'b0;
    end else if (flush_i) begin
      vld_p0  <= 1'b0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      pc_p0   <= in_pc_i;
      rs1_p0  <= ir[19:15];
      rs2_p0  <= ir[24:20];
      rd_p0   <= ir[11:7];
      f3_p0   <= f3;
      f7_p0   <= ir[30];
      imm_p0  <= imm_d;
      os_p0   <= os_d;
      ctrl_p0 <= ctrl_d;
      ill_p0  <= illegal_d;
    end else if (out_ready_i) begin
      vld_p0  <= 1'b0;
    end
  end

  assign out_valid_o = vld_p0;
  assign out_pc_o    = pc_p0;
  assign rs1_o       = rs1_p0;
  assign rs2_o       = rs2_p0;
  assign rd_o        = rd_p0;
  assign funct3_o    = f3_p0;
  assign funct7_o    = f7_p0;
  assign imm_o       = imm_p0;
  assign op_sel_o    = os_p0;
  assign reg_we_o    = ctrl_p0.reg_we;
  assign load_o      = ctrl_p0.load;
  assign store_o     = ctrl_p0.store;
  assign lui_o       = ctrl_p0.lui;
  assign auipc_o     = ctrl_p0.auipc;
  assign branch_o    = ctrl_p0.branch;
  assign jal_o       = ctrl_p0.jal;
  assign jalr_o      = ctrl_p0.jalr;
  assign muldiv_o    = ctrl_p0.muldiv;
  assign word_o      = ctrl_p0.word;
  assign ecall_o     = ctrl_p0.ecall;
  assign ebreak_o    = ctrl_p0.ebreak;
  assign illegal_o   = ill_p0;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: three decoder configurations (RV32, RV32+M, RV64+M) driven in
// lockstep; a scoreboard queue per instance holds hand-computed expectations.
module tb_decode_stage;

  localparam logic [11:0] F_WE = 12'h800, F_LD = 12'h400, F_ST = 12'h200;
  localparam logic [11:0] F_LUI = 12'h100, F_AUI = 12'h080, F_BR = 12'h040;
  localparam logic [11:0] F_JAL = 12'h020, F_MD = 12'h008, F_W = 12'h004;
  localparam logic [11:0] F_EC = 12'h002, F_EB = 12'h001;
  localparam int NV = 17;

  typedef struct packed {
    logic [31:0] ir;
    logic        ill;
    logic [11:0] fl;
    logic [1:0]  os;
    logic [63:0] imm;
    logic [63:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_ir = 32'h0;
  logic [63:0] in_pc = 64'h0;
  logic [31:0] in_pc32;
  assign in_pc32 = in_pc[31:0];

  int n_cmp = 0;
  int n_err = 0;
  exp_t q_a[$], q_b[$], q_c[$];

  // ir, illegal mask {rv32, rv32m, rv64m}, flags/op_sel/imm when legal
  logic [31:0] v_ir  [NV] = '{32'hFFF00093, 32'h008000EF, 32'h12345037, 32'h022081B3,
                              32'h00000000, 32'h0000B183, 32'hFFF0009B, 32'h00000073,
                              32'h00100073, 32'h00208863, 32'hFE20AE23, 32'h00001297,
                              32'h403110B3, 32'h403100B3, 32'h000090E7, 32'h02009093,
                              32'h0000000F};
  logic [2:0]  v_ill [NV] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b111, 3'b110, 3'b110,
                              3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000,
                              3'b111, 3'b110, 3'b000};
  logic [11:0] v_fl  [NV] = '{F_WE, F_WE | F_JAL, F_LUI, F_WE | F_MD, 12'h0, F_WE | F_LD,
                              F_WE | F_W, F_EC, F_EB, F_BR, F_ST, F_WE | F_AUI, 12'h0,
                              F_WE, 12'h0, F_WE, 12'h0};
  logic [1:0]  v_os  [NV] = '{2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00,
                              2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10,
                              2'b00};
  logic [31:0] v_imm [NV] = '{32'hFFFFFFFF, 32'h00000008, 32'h12345000, 32'h0, 32'h0,
                              32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000010,
                              32'hFFFFFFFC, 32'h00001000, 32'h0, 32'h0, 32'h0,
                              32'h00000020, 32'h0};

  wire        a_valid, b_valid, c_valid, a_ready, b_ready, c_ready;
  wire [31:0] a_pc, b_pc, a_imm, b_imm;
  wire [63:0] c_pc, c_imm;
  wire [18:0] a_fd, b_fd, c_fd;
  wire [11:0] a_fl, b_fl, c_fl;
  wire [1:0]  a_os, b_os, c_os;
  wire        a_ill, b_ill, c_ill;

  decode_stage #(.XLEN(32), .EN_M(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(a_ready), .in_ir_i(in_ir), .in_pc_i(in_pc32),
    .out_valid_o(a_valid), .out_ready_i(out_ready), .out_pc_o(a_pc),
    .rs1_o(a_fd[18:14]), .rs2_o(a_fd[13:9]), .rd_o(a_fd[8:4]),
    .funct3_o(a_fd[3:1]), .funct7_o(a_fd[0]), .imm_o(a_imm), .op_sel_o(a_os),
    .reg_we_o(a_fl[11]), .load_o(a_fl[10]), .store_o(a_fl[9]), .lui_o(a_fl[8]),
    .auipc_o(a_fl[7]), .branch_o(a_fl[6]), .jal_o(a_fl[5]), .jalr_o(a_fl[4]),
    .muldiv_o(a_fl[3]), .word_o(a_fl[2]), .ecall_o(a_fl[1]), .ebreak_o(a_fl[0]),
    .illegal_o(a_ill));

  decode_stage #(.XLEN(32), .EN_M(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(b_ready), .in_ir_i(in_ir), .in_pc_i(in_pc32),
    .out_valid_o(b_valid), .out_ready_i(out_ready), .out_pc_o(b_pc),
    .rs1_o(b_fd[18:14]), .rs2_o(b_fd[13:9]), .rd_o(b_fd[8:4]),
    .funct3_o(b_fd[3:1]), .funct7_o(b_fd[0]), .imm_o(b_imm), .op_sel_o(b_os),
    .reg_we_o(b_fl[11]), .load_o(b_fl[10]), .store_o(b_fl[9]), .lui_o(b_fl[8]),
    .auipc_o(b_fl[7]), .branch_o(b_fl[6]), .jal_o(b_fl[5]), .jalr_o(b_fl[4]),
    .muldiv_o(b_fl[3]), .word_o(b_fl[2]), .ecall_o(b_fl[1]), .ebreak_o(b_fl[0]),
    .illegal_o(b_ill));

  decode_stage #(.XLEN(64), .EN_M(1'b1)) dut_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(c_ready), .in_ir_i(in_ir), .in_pc_i(in_pc),
    .out_valid_o(c_valid), .out_ready_i(out_ready), .out_pc_o(c_pc),
    .rs1_o(c_fd[18:14]), .rs2_o(c_fd[13:9]), .rd_o(c_fd[8:4]),
    .funct3_o(c_fd[3:1]), .funct7_o(c_fd[0]), .imm_o(c_imm), .op_sel_o(c_os),
    .reg_we_o(c_fl[11]), .load_o(c_fl[10]), .store_o(c_fl[9]), .lui_o(c_fl[8]),
    .auipc_o(c_fl[7]), .branch_o(c_fl[6]), .jal_o(c_fl[5]), .jalr_o(c_fl[4]),
    .muldiv_o(c_fl[3]), .word_o(c_fl[2]), .ecall_o(c_fl[1]), .ebreak_o(c_fl[0]),
    .illegal_o(c_ill));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pc_of(input int i);
    return 64'h8000_0000_0000_1000 + 64'(i) * 64'd4;
  endfunction

  // cfg 0 = RV32, 1 = RV32+M, 2 = RV64+M
  function automatic exp_t mk(input int i, input int cfg);
    exp_t        e;
    logic [2:0]  im;
    logic [63:0] p;
    logic [31:0] v;
    im    = v_ill[i];
    p     = pc_of(i);
    v     = v_imm[i];
    e.ir  = v_ir[i];
    e.pc  = (cfg == 2) ? p : {32'h0, p[31:0]};
    e.ill = im[2-cfg];
    if (e.ill) begin
      e.fl  = '0;
      e.os  = '0;
      e.imm = '0;
    end else begin
      e.fl  = v_fl[i];
      e.os  = v_os[i];
      e.imm = (cfg == 2) ? {{32{v[31]}}, v} : {32'h0, v};
    end
    return e;
  endfunction

  task automatic check_dut(input string tag, input exp_t e, input logic ill,
                           input logic [11:0] fl, input logic [1:0] os,
                           input logic [63:0] imm, input logic [63:0] pc,
                           input logic [18:0] fd);
    logic [31:0] r;
    r = e.ir;
    chk({tag, "_illegal"}, 64'(ill), 64'(e.ill));
    chk({tag, "_flags"}, 64'(fl), 64'(e.fl));
    chk({tag, "_op_sel"}, 64'(os), 64'(e.os));
    chk({tag, "_imm"}, imm, e.imm);
    chk({tag, "_pc"}, pc, e.pc);
    chk({tag, "_fields"}, 64'(fd), 64'({r[19:15], r[24:20], r[11:7], r[14:12], r[30]}));
  endtask

  // Monitor: an output presented with out_ready high is consumed at the next edge.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (a_valid) begin
        if (q_a.size() == 0) chk("a_unexpected_output", 64'd1, 64'd0);
        else check_dut("a", q_a.pop_front(), a_ill, a_fl, a_os, {32'h0, a_imm},
                       {32'h0, a_pc}, a_fd);
      end
      if (b_valid) begin
        if (q_b.size() == 0) chk("b_unexpected_output", 64'd1, 64'd0);
        else check_dut("b", q_b.pop_front(), b_ill, b_fl, b_os, {32'h0, b_imm},
                       {32'h0, b_pc}, b_fd);
      end
      if (c_valid) begin
        if (q_c.size() == 0) chk("c_unexpected_output", 64'd1, 64'd0);
        else check_dut("c", q_c.pop_front(), c_ill, c_fl, c_os, c_imm, c_pc, c_fd);
      end
    end
  end

  task automatic drive(input int i);
    in_ir = v_ir[i];
    in_pc = pc_of(i);
  endtask

  task automatic push_all(input int i);
    q_a.push_back(mk(i, 0));
    q_b.push_back(mk(i, 1));
    q_c.push_back(mk(i, 2));
  endtask

  // Offer vector i until accepted (bounded), then return just after the edge.
  task automatic send(input int i);
    int t;
    t = 0;
    in_valid = 1'b1;
    drive(i);
    @(negedge clk);
    while (!(a_ready && b_ready && c_ready) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!(a_ready && b_ready && c_ready)) chk("accept_timeout", 64'd0, 64'd1);
    else push_all(i);
    @(posedge clk);
    #1;
  endtask

  logic [63:0] s_imm, s_pc;
  logic [11:0] s_fl;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'({a_valid, b_valid, c_valid}), 64'd0);
    chk("reset_imm", c_imm, 64'd0);
    chk("reset_pc", c_pc, 64'd0);
    chk("reset_illegal", 64'({a_ill, b_ill, c_ill}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // back-to-back stream with execute always ready
    for (int i = 0; i < NV; i++) send(i);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // stall: execute not ready for 3 cycles, next instruction waiting
    out_ready = 1'b0;
    send(0);
    drive(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        s_imm = c_imm;
        s_pc  = c_pc;
        s_fl  = c_fl;
      end
      chk("stall_in_ready", 64'({a_ready, c_ready}), 64'd0);
      chk("stall_valid", 64'({a_valid, c_valid}), 64'b11);
      chk("stall_imm_hold", c_imm, s_imm);
      chk("stall_pc_hold", c_pc, s_pc);
      chk("stall_flags_hold", 64'(c_fl), 64'(s_fl));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'({a_ready, c_ready}), 64'b11);
    if (a_ready && b_ready && c_ready) push_all(1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("no_bubble_valid", 64'({a_valid, c_valid}), 64'b11);
    repeat (2) @(posedge clk);
    #1;

    // flush while holding an instruction and fetch offering another
    out_ready = 1'b0;
    send(2);
    drive(3);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'({a_ready, b_ready, c_ready}), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    q_a.delete();
    q_b.delete();
    q_c.delete();
    @(negedge clk);
    chk("flush_valid", 64'({a_valid, b_valid, c_valid}), 64'd0);
    @(posedge clk);
    #1;

    // asynchronous reset while stalled
    send(11);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'({a_valid, b_valid, c_valid}), 64'd0);
    chk("async_rst_imm", c_imm, 64'd0);
    chk("async_rst_pc", c_pc, 64'd0);
    chk("async_rst_flags", 64'({a_fl, c_fl}), 64'd0);
    q_a.delete();
    q_b.delete();
    q_c.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'({a_ready, b_ready, c_ready}), 64'b111);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
